// File: rtl/fsk_pkg.sv
// fsk_pkg: shared definitions for the two-tone FSK link (transmitter and
// frequency analyzer). Defining FSK_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
package fsk_pkg;

    // Frame layout
    localparam int unsigned FSK_DATA_BITS = 8;
    localparam int unsigned FSK_IDX_W     = $clog2(FSK_DATA_BITS);
`ifdef FSK_TX_PARITY_EN
    localparam int unsigned FSK_FRAME_BITS = 11;
`else
    localparam int unsigned FSK_FRAME_BITS = 10;
`endif

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef FSK_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } fsk_state_t;

    // Half-period of a tone in clock cycles, integer-truncated. The analyzer
    // uses the same function so both ends agree on the classification window.
    function automatic int unsigned fsk_half_period(input int unsigned clk_hz,
                                                    input int unsigned tone_hz);
        return clk_hz / (32'd2 * tone_hz);
    endfunction

endpackage

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator: phase-continuous two-tone square wave. A down-counter
// runs from H(bit) to 1; at 1 the output toggles and the counter reloads with
// the half-period of the bit currently selected. Changing bit_value never
// forces a toggle; the new tone applies from the next reload onwards.
module fsk_tone_generator #(
    parameter int unsigned H1 = 10,
    parameter int unsigned H2 = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic bit_value,
    output logic tx_out
);

    localparam int unsigned CW = $clog2(H1 + 1);
    localparam logic [CW-1:0] CNT_H1  = CW'(H1);
    localparam logic [CW-1:0] CNT_H2  = CW'(H2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_tx;
    logic [CW-1:0] w_reload;

    // Half-period to use on the next reload
    assign w_reload = bit_value ? CNT_H2 : CNT_H1;

    // Reload counter and toggle flop; a zero count marks a fresh start from idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_tx  <= 1'b0;
        end else if (!run) begin
            r_cnt <= '0;
            r_tx  <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt <= CNT_H1;
            r_tx  <= 1'b0;
        end else if (r_cnt == CNT_ONE) begin
            r_cnt <= w_reload;
            r_tx  <= ~r_tx;
        end else begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign tx_out = r_tx;

endmodule

// File: rtl/fsk_transmitter.sv
// fsk_transmitter: serialises bytes into start / 8 data (LSB first) / stop
// frames and sends each bit as a tone: FREQUENCY_1 for 0, FREQUENCY_2 for 1.
// Defining FSK_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//
// Handshake: a byte is accepted on any rising edge where valid && ready.
// ready is high in IDLE and in the last STOP cycle while enabled, so frames
// can run back to back with no idle gap; valid may wait indefinitely and
// data must stay stable until it is accepted.
module fsk_transmitter import fsk_pkg::*; #(
    parameter int unsigned FREQUENCY_1 = 9000,
    parameter int unsigned FREQUENCY_2 = 11000,
    parameter int unsigned CLOCK       = 50000000,
    parameter int unsigned BAUD        = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx_out
);

    localparam int unsigned H1        = fsk_half_period(CLOCK, FREQUENCY_1);
    localparam int unsigned H2        = fsk_half_period(CLOCK, FREQUENCY_2);
    localparam int unsigned BIT_TICKS = CLOCK / BAUD;
    localparam int unsigned TW        = $clog2(BIT_TICKS);

    localparam logic [TW-1:0]        TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0]        TICK_ONE  = TW'(1);
    localparam logic [FSK_IDX_W-1:0] IDX_LAST  = FSK_IDX_W'(FSK_DATA_BITS - 1);
    localparam logic [FSK_IDX_W-1:0] IDX_ONE   = FSK_IDX_W'(1);

    // Reject parameter sets whose tones cannot be told apart or do not fit a bit
    if (H2 < 2 || H1 <= H2 || BIT_TICKS < 2 * H1) begin : g_bad_params
        $error("fsk_transmitter: invalid tone/baud parameters (H1=%0d H2=%0d BIT_TICKS=%0d)",
               H1, H2, BIT_TICKS);
    end

    fsk_state_t           r_state;
    fsk_state_t           w_state_next;
    logic [TW-1:0]        r_tick;
    logic [TW-1:0]        w_tick_next;
    logic [FSK_IDX_W-1:0] r_idx;
    logic [FSK_IDX_W-1:0] w_idx_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
`ifdef FSK_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_next;
`endif
    logic                 r_rst_done;
    logic                 w_bit_end;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_run;
    logic                 w_tone_bit;

    assign w_bit_end = (r_tick == TICK_LAST);
    assign w_ready   = enable && r_rst_done &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
    assign w_accept  = valid && w_ready;

    // Holds ready low while reset is asserted and until the first edge after it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    // FSM, bit timer, data index and shift register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_tick   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef FSK_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_tick   <= w_tick_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
`ifdef FSK_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    // Next-state logic plus the bit the tone generator sends after this edge
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick + TICK_ONE;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
`ifdef FSK_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        w_tone_bit    = 1'b0;

        if (!enable) begin
            // Abort: drop the frame and the latched byte
            w_state_next  = ST_IDLE;
            w_tick_next   = '0;
            w_idx_next    = '0;
            w_shift_next  = '0;
`ifdef FSK_TX_PARITY_EN
            w_parity_next = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_tick_next = '0;
                    if (w_accept) begin
                        w_state_next  = ST_START;
                        w_idx_next    = '0;
                        w_shift_next  = data;
`ifdef FSK_TX_PARITY_EN
                        w_parity_next = ^data;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        w_state_next = ST_DATA;
                        w_tick_next  = '0;
                        w_idx_next   = '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        w_tick_next  = '0;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        if (r_idx == IDX_LAST) begin
                            w_idx_next = '0;
`ifdef FSK_TX_PARITY_EN
                            w_state_next = ST_PARITY;
`else
                            w_state_next = ST_STOP;
`endif
                        end else begin
                            w_idx_next = r_idx + IDX_ONE;
                        end
                    end
                end
`ifdef FSK_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        w_state_next = ST_STOP;
                        w_tick_next  = '0;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        w_tick_next = '0;
                        if (w_accept) begin
                            // Gapless follow-on frame; the tone keeps its phase
                            w_state_next  = ST_START;
                            w_idx_next    = '0;
                            w_shift_next  = data;
`ifdef FSK_TX_PARITY_EN
                            w_parity_next = ^data;
`endif
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_tick_next  = '0;
                end
            endcase
        end

        case (w_state_next)
            ST_DATA:   w_tone_bit = w_shift_next[0];
`ifdef FSK_TX_PARITY_EN
            ST_PARITY: w_tone_bit = w_parity_next;
`endif
            ST_STOP:   w_tone_bit = 1'b1;
            default:   w_tone_bit = 1'b0;
        endcase
    end

    assign w_run = (w_state_next != ST_IDLE);

    fsk_tone_generator #(
        .H1 (H1),
        .H2 (H2)
    ) u_tone (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (w_run),
        .bit_value (w_tone_bit),
        .tx_out    (tx_out)
    );

    assign ready = w_ready;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fsk_transmitter.sv
// tb_fsk_transmitter: directed checks of the FSK transmitter with
// CLOCK=1000, FREQUENCY_1=50, FREQUENCY_2=100, BAUD=10 (H1=10, H2=5,
// BIT_TICKS=100). Honours FSK_TX_PARITY_EN for the frame length.
module tb_fsk_transmitter;

    localparam int BT = 100;
    localparam int H1 = 10;
    localparam int H2 = 5;
`ifdef FSK_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FC = NB * BT;

    // ---------------- clock / reset / DUT ----------------
    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       tx_out;

    always #5 clock = ~clock;

    fsk_transmitter #(
        .FREQUENCY_1 (50),
        .FREQUENCY_2 (100),
        .CLOCK       (1000),
        .BAUD        (10)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .tx_out  (tx_out)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [0:0] exp_q[$];
    int         tog_q[$];
    bit         busy_a  [0:2*FC+4];
    bit         ready_a [0:2*FC+4];
    bit         tx_a    [0:2*FC+4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected on-air bits of one frame
    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef FSK_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // ---------------- driver tasks ----------------
    // Presents d and returns #1 after the accepting edge
    task automatic send_byte(input logic [7:0] d, input bit keep_valid);
        bit accepted;
        accepted = 1'b0;
        data  = d;
        valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (ready) begin
                @(posedge clock); #1;
                accepted = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!keep_valid) valid = 1'b0;
        check("accept", int'(accepted), 1);
    endtask

    // Samples #1 after each of the next ncyc edges; records toggle times
    task automatic capture(input int ncyc, input int drop_valid_k);
        logic prev;
        tog_q.delete();
        prev = tx_out;
        busy_a[0] = busy; ready_a[0] = ready; tx_a[0] = tx_out;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock); #1;
            busy_a[k] = busy; ready_a[k] = ready; tx_a[k] = tx_out;
            if (k < ncyc && tx_out !== prev) tog_q.push_back(k);
            prev = tx_out;
            if (k == drop_valid_k) valid = 1'b0;
        end
    endtask

    // Decodes each bit window from the recorded toggles and checks intervals
    task automatic check_bits(input string tag, input int nbits);
        int meas, iv, bad;
        bit found;
        for (int b = 0; b < nbits; b++) begin
            found = 1'b0;
            meas  = 2;
            for (int i = 0; i + 1 < tog_q.size(); i++) begin
                if (!found && tog_q[i] >= b * BT && tog_q[i+1] <= (b + 1) * BT) begin
                    iv    = tog_q[i+1] - tog_q[i];
                    meas  = (iv == H2) ? 1 : ((iv == H1) ? 0 : 2);
                    found = 1'b1;
                end
            end
            check($sformatf("%s_bit%0d", tag, b), meas, int'(exp_q.pop_front()));
        end
        bad = 0;
        for (int i = 0; i + 1 < tog_q.size(); i++) begin
            iv = tog_q[i+1] - tog_q[i];
            if (iv != H1 && iv != H2) bad++;
        end
        check({tag, "_bad_intervals"}, bad, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d);
        push_frame(d);
        send_byte(d, 1'b0);
        check({tag, "_busy_after_accept"}, int'(busy), 1);
        capture(FC, -1);
        check({tag, "_first_toggle"}, (tog_q.size() > 0) ? tog_q[0] : -1, H1);
        check({tag, "_busy_last"}, int'(busy_a[FC-1]), 1);
        check({tag, "_busy_end"}, int'(busy_a[FC]), 0);
        check({tag, "_tx_end"}, int'(tx_a[FC]), 0);
        check({tag, "_ready_end"}, int'(ready_a[FC]), 1);
        check_bits(tag, NB);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_lo;
        reset_n = 1'b0;
        enable  = 1'b1;
        valid   = 1'b0;
        data    = 8'h00;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", int'(tx_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        check("rel_ready", int'(ready), 1);

        // Reset in the middle of a frame (0xA5: bit1 is f2, tx high after edge 107)
        send_byte(8'hA5, 1'b0);
        repeat (107) @(posedge clock);
        #1;
        check("pre_reset_tx", int'(tx_out), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_tx", int'(tx_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(ready), 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        check("mid_rel_ready", int'(ready), 1);
        check("mid_rel_busy", int'(busy), 0);

        // Single frames
        run_frame("f00", 8'h00);
        run_frame("fa5", 8'hA5);

        // Back-to-back 0xFF then 0x01 with valid held
        push_frame(8'hFF);
        push_frame(8'h01);
        send_byte(8'hFF, 1'b1);
        data = 8'h01;
        capture(2 * FC, FC);
        check("b2b_ready_early", int'(ready_a[FC-2]), 0);
        check("b2b_ready_last", int'(ready_a[FC-1]), 1);
        busy_lo = 0;
        for (int k = 1; k < 2 * FC; k++) if (!busy_a[k]) busy_lo++;
        check("b2b_busy_gap", busy_lo, 0);
        check("b2b_busy_end", int'(busy_a[2*FC]), 0);
        check("b2b_toggle_at_join", (tog_q.size() > 0) ? int'(tx_a[FC] != tx_a[FC-1]) : -1, 1);
        check_bits("b2b", 2 * NB);

        // Enable dropped at cycle 350 of a frame
        send_byte(8'h3C, 1'b0);
        repeat (349) @(posedge clock);
        #1;
        check("en_busy_before", int'(busy), 1);
        enable = 1'b0;
        @(posedge clock); #1;
        check("en_drop_busy", int'(busy), 0);
        check("en_drop_tx", int'(tx_out), 0);
        check("en_drop_ready", int'(ready), 0);
        enable = 1'b1;
        #1;
        check("en_back_ready", int'(ready), 1);
        run_frame("fresh", 8'h00);

        // 0x07: three ones, parity bit 1 when parity is enabled
        run_frame("f07", 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "time limit");
    end

endmodule
